// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Board-side input conditioner and run/halt/single-step control for
// pipeline_top. Raw buttons and the result-select switch are synchronised,
// debounced and edge-detected. A 3-state FSM (RUN/HALT/STEP) then drives the
// registered stop, running and step_count outputs.
//
// Build option: define SIM_NO_DEBOUNCE_EN to bypass the debounce counters.
// Each debounced level then follows its synchronised input every cycle.
// This is meant for fast-clock simulation. The parameters stay declared.
module pipeline_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int STEP_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_stop,
    input  logic              btn_step,
    input  logic              sw_res,
    output logic              stop,
    output logic              switch_res,
    output logic              running,
    output logic [STEP_W-1:0] step_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // Bit positions of the three conditioned inputs.
    localparam int N_IN     = 3;
    localparam int IDX_STOP = 0;
    localparam int IDX_STEP = 1;
    localparam int IDX_SW   = 2;

    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] sync_meta;
    logic [N_IN-1:0] sync_s;
    logic [N_IN-1:0] in_db;
    logic [1:0]      btn_db_q;
    logic            stop_rise;
    logic            step_rise;
    state_t          state_q;
    state_t          state_next;

    assign raw_in = {sw_res, btn_step, btn_stop};

    // Two-flop synchroniser on every asynchronous input.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= raw_in;
            sync_s    <= sync_meta;
        end
    end

`ifdef SIM_NO_DEBOUNCE_EN
    // Debounce bypassed: the stable level tracks the synchronised input directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_db <= '0;
        end else begin
            in_db <= sync_s;
        end
    end
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [N_IN];

    // Per-input debounce: accept a new level only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts the count.
    // NOTE: the counter array is ordinary control state, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_db <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_s[i] == in_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    in_db[i]  <= sync_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`endif

    // One-cycle delayed copy of the debounced buttons for rise detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db_q <= '0;
        end else begin
            btn_db_q <= in_db[IDX_STEP:IDX_STOP];
        end
    end

    assign stop_rise = in_db[IDX_STOP] & ~btn_db_q[IDX_STOP];
    assign step_rise = in_db[IDX_STEP] & ~btn_db_q[IDX_STEP];

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic. A stop press beats a step press in HALT, and STEP
    // always lasts exactly one cycle.
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_RUN: begin
                if (stop_rise) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (stop_rise) begin
                    state_next = ST_RUN;
                end else if (step_rise) begin
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Outputs registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop       <= 1'b0;
            running    <= 1'b1;
            switch_res <= 1'b0;
            step_count <= '0;
        end else begin
            stop       <= (state_next == ST_HALT);
            running    <= (state_next == ST_RUN);
            switch_res <= in_db[IDX_SW];
            if (state_next == ST_STEP) begin
                step_count <= step_count + STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Testbench for pipeline_run_ctrl. The DUT is built with DEBOUNCE_CYCLES=4,
// so a raw change reaches stop/switch_res 7 edges later. STEP_W=2 lets the
// step counter wrap after 4 steps. A table of level/hold/expect records covers
// the bulk of the behaviour. Hand-written sequences cover reset release and
// reset during STEP. When the bench is built with SIM_NO_DEBOUNCE_EN, it runs
// the 4-edge bypass checks instead of the table.
module tb_pipeline_run_ctrl;

    localparam int DC     = 4;
    localparam int CNT_W  = 20;
    localparam int STEP_W = 2;

    logic              clk;
    logic              rst;
    logic              btn_stop;
    logic              btn_step;
    logic              sw_res;
    logic              stop;
    logic              switch_res;
    logic              running;
    logic [STEP_W-1:0] step_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       bs;
        logic       bt;
        logic       sw;
        logic [7:0] n;
        logic       es;
        logic       er;
        logic       esw;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];

    pipeline_run_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CNT_W),
        .STEP_W         (STEP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_stop  (btn_stop),
        .btn_step  (btn_step),
        .sw_res    (sw_res),
        .stop      (stop),
        .switch_res(switch_res),
        .running   (running),
        .step_count(step_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_all(input string tag, input logic es, input logic er,
                             input logic esw, input logic [1:0] ec);
        check({tag, ".stop"},       32'(stop),       32'(es));
        check({tag, ".running"},    32'(running),    32'(er));
        check({tag, ".switch_res"}, 32'(switch_res), 32'(esw));
        check({tag, ".step_count"}, 32'(step_count), 32'(ec));
    endtask

    task automatic add(input logic bs, input logic bt, input logic sw, input int n,
                       input logic es, input logic er, input logic esw, input int ec);
        vec_t v;
        v.bs  = bs;
        v.bt  = bt;
        v.sw  = sw;
        v.n   = 8'(n);
        v.es  = es;
        v.er  = er;
        v.esw = esw;
        v.ec  = 2'(ec);
        vecs.push_back(v);
    endtask

    initial begin
        rst      = 1'b0;
        btn_stop = 1'b1;
        btn_step = 1'b0;
        sw_res   = 1'b0;

        // Reset held with btn_stop pressed: nothing may propagate.
        repeat (4) tick();
        check_all("reset_hold", 1'b0, 1'b1, 1'b0, 2'd0);

`ifndef SIM_NO_DEBOUNCE_EN
        // Release reset with btn_stop still pressed: HALT at edge 7.
        rst = 1'b1;
        repeat (6) tick();
        check_all("rel_edge6", 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        check_all("rel_edge7", 1'b1, 1'b0, 1'b0, 2'd0);

        // Fields: btn_stop, btn_step, sw_res, edges to hold, then the
        // expected stop, running, switch_res and step_count.
        add(0, 0, 0, 12, 1, 0, 0, 0);       // release gives no action
        add(1, 0, 0,  6, 1, 0, 0, 0);       // resume press, not yet accepted
        add(1, 0, 0,  1, 0, 1, 0, 0);       // edge 7: RUN
        add(1, 0, 0, 10, 0, 1, 0, 0);       // held: a single action only
        add(0, 0, 0, 12, 0, 1, 0, 0);
        add(1, 0, 0,  3, 0, 1, 0, 0);       // 3-cycle glitch
        add(0, 0, 0, 12, 0, 1, 0, 0);       // rejected
        add(1, 0, 0,  6, 0, 1, 0, 0);       // 10-cycle pulse
        add(1, 0, 0,  1, 1, 0, 0, 0);       // edge 7: HALT
        add(1, 0, 0,  3, 1, 0, 0, 0);
        add(0, 0, 0, 12, 1, 0, 0, 0);       // stays halted after release
        add(0, 0, 1,  6, 1, 0, 0, 0);       // sw_res rise
        add(0, 0, 1,  1, 1, 0, 1, 0);
        add(0, 0, 0,  6, 1, 0, 1, 0);       // sw_res fall
        add(0, 0, 0,  1, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin  // four steps; the 4th wraps to 0
            add(0, 1, 0,  6, 1, 0, 0, (k - 1) % 4);
            add(0, 1, 0,  1, 0, 0, 0, k % 4);   // single-cycle stop=0
            add(0, 1, 0,  1, 1, 0, 0, k % 4);
            add(0, 1, 0,  2, 1, 0, 0, k % 4);
            add(0, 0, 0, 12, 1, 0, 0, k % 4);
        end
        add(1, 0, 0,  6, 1, 0, 0, 0);       // resume
        add(1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 12, 0, 1, 0, 0);
        add(0, 1, 0, 10, 0, 1, 0, 0);       // step press in RUN is ignored
        add(0, 0, 0, 12, 0, 1, 0, 0);
        add(1, 0, 0,  7, 1, 0, 0, 0);       // halt
        add(0, 0, 0, 12, 1, 0, 0, 0);
        add(1, 1, 0,  6, 1, 0, 0, 0);       // both rise together in HALT
        add(1, 1, 0,  1, 0, 1, 0, 0);       // stop wins: RUN
        add(1, 1, 0, 10, 0, 1, 0, 0);
        add(0, 0, 0, 12, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            btn_stop = vecs[i].bs;
            btn_step = vecs[i].bt;
            sw_res   = vecs[i].sw;
            repeat (int'(vecs[i].n)) tick();
            check_all($sformatf("vec%0d", i), vecs[i].es, vecs[i].er, vecs[i].esw, vecs[i].ec);
        end

        // Reset asserted during the STEP cycle clears everything at once.
        btn_stop = 1'b1;
        repeat (7) tick();
        check_all("mid_halt", 1'b1, 1'b0, 1'b0, 2'd0);
        btn_stop = 1'b0;
        repeat (12) tick();
        btn_step = 1'b1;
        repeat (7) tick();
        check_all("mid_step", 1'b0, 1'b0, 1'b0, 2'd1);
        rst = 1'b0;
        #1;
        check_all("rst_in_step", 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (2) tick();
        btn_step = 1'b0;
        rst = 1'b1;
        repeat (12) tick();
        check_all("post_rst", 1'b0, 1'b1, 1'b0, 2'd0);
`else
        // Bypass build: a raw change reaches the outputs in 4 edges.
        btn_stop = 1'b0;
        rst = 1'b1;
        repeat (8) tick();
        check_all("byp_idle", 1'b0, 1'b1, 1'b0, 2'd0);
        sw_res = 1'b1;
        tick();
        sw_res = 1'b0;
        repeat (2) tick();
        check_all("byp_sw_e3", 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        check_all("byp_sw_e4", 1'b0, 1'b1, 1'b1, 2'd0);
        tick();
        check_all("byp_sw_e5", 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (4) tick();
        btn_stop = 1'b1;
        repeat (3) tick();
        check_all("byp_stop_e3", 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        check_all("byp_stop_e4", 1'b1, 1'b0, 1'b0, 2'd0);
        btn_stop = 1'b0;
        repeat (6) tick();
        btn_step = 1'b1;
        repeat (4) tick();
        check_all("byp_step_on", 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        check_all("byp_step_off", 1'b1, 1'b0, 1'b0, 2'd1);
        btn_step = 1'b0;
        repeat (6) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Board-side input conditioner and run-control for the dynamic pipeline top level. It takes raw push-buttons and the result-select switch, then synchronises and debounces them. It produces the `stop` and `switch_res` levels that `pipeline_top` consumes, which lets an operator halt the pipeline, resume it, or advance it exactly one clock at a time. It sits between the board I/O pins and `pipeline_top`, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a synchronised input must hold a new value before it is accepted; legal range 1 … 2^CNT_W−1.
- `CNT_W`, 20: debounce counter width.
- `STEP_W`, 16: width of the step counter.

- `clk`  in  1  system clock, same clock as `pipeline_top`.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_stop`  in  1  raw run/halt toggle button, active-high, asynchronous to `clk`.
- `btn_step`  in  1  raw single-step button, active-high, asynchronous.
- `sw_res`  in  1  raw result-select switch, asynchronous.
- `stop`  out  1  registered; 1 holds the pipeline, 0 lets it advance. Drives `pipeline_top.stop`.
- `switch_res`  out  1  registered, debounced copy of `sw_res`. Drives `pipeline_top.switch_res`.
- `running`  out  1  registered; 1 while in RUN (status LED).
- `step_count`  out  STEP_W  registered; number of single steps taken since reset.

## Operation
- **Synchroniser:** every raw input passes through its own 2-flop synchroniser (`*_s`).
- **Debouncer:** each input has its own debounce counter and a stable register (`*_db`).
  - If `*_s == *_db`, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, `*_db` takes `*_s` on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- **Edge detect:** `stop_rise = btn_stop_db & ~btn_stop_db_q` and `step_rise` likewise. `*_db_q` is a one-cycle delayed copy of `*_db`.
- **FSM** (3 states, reset state RUN):
  - RUN: `stop_rise` → HALT. `step_rise` is ignored.
  - HALT: `stop_rise` → RUN. Otherwise `step_rise` → STEP. If both rise in the same cycle, `stop_rise` wins and the next state is RUN.
  - STEP: always → HALT after exactly one cycle. Any rises in this cycle are ignored.
- **Outputs:** all registered from the next state.
  - `stop = (next == HALT)`
  - `running = (next == RUN)`
  - `step_count` increments by 1 on entry to STEP and wraps from 2^STEP_W−1 to 0.
  - `switch_res` is the registered copy of `sw_res_db`.
- **Reset:** asserting `rst` at any time (including mid-debounce or in STEP) asynchronously clears all state, with no step completed.
- **Reset values:**
  - `stop` = 0, `switch_res` = 0, `running` = 1, `step_count` = 0.
  - All synchroniser flops, `*_db`, `*_db_q` and counters = 0.
  - FSM = RUN.

## Timing
- Raw edge sampled at edge 0:
  - `*_s` changes at edge 2.
  - `*_db` changes at edge 1+DEBOUNCE_CYCLES+1.
  - The FSM state and `stop` change one edge later, i.e. DEBOUNCE_CYCLES+3 edges after the raw change.
- `switch_res` follows `sw_res` with the same DEBOUNCE_CYCLES+3 latency.
- **Single step:** `stop` is 0 for exactly one `clk` cycle per accepted step press, then returns to 1.
- A held button produces one action only. The next action needs a debounced release and press.
- Releases produce no action.

## Configuration
- `SIM_NO_DEBOUNCE_EN`:
  - Defined: the debounce counters are removed and `*_db` registers `*_s` directly every cycle. Latency from raw change to `stop` and `switch_res` becomes 4 edges. This is used for fast-clock simulation benches.
  - Undefined: full debounce as specified above.
  - The parameters remain declared in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and the macro undefined, unless noted.
- **Reset:** hold `rst`=0 with `btn_stop`=1 → `stop`=0, `running`=1, `step_count`=0. Release `rst` with `btn_stop` still 1 → `stop`=1 at edge 7 after release.
- **Glitch rejection:** `btn_stop` pulse 3 cycles wide → `stop` stays 0. Pulse 10 cycles wide → `stop`=1 exactly 7 edges after the rising edge, and stays 1 after release.
- **Single step:** from HALT, press `btn_step` three times, each held 10 cycles → three single-cycle `stop`=0 windows, `step_count` = 3, `running` = 0 throughout. A press in RUN → `step_count` unchanged.
- **Simultaneous events:** in HALT, raise `btn_stop` and `btn_step` on the same cycle → FSM goes to RUN, `stop`=0 and stays 0, `step_count` unchanged.
- **Wrap and reset mid-step:** preload 0xFFFF steps (or force STEP_W=2 and do 4 steps) → `step_count` wraps to 0. Assert `rst` during the STEP cycle → `stop`=0, `running`=1, `step_count`=0 immediately.
- **Macro build** with `SIM_NO_DEBOUNCE_EN` defined: a 1-cycle `sw_res` pulse → `switch_res` pulses for 1 cycle, 4 edges later.
